shift_deser: RTL and testbench

//  Serial-in/parallel-out receiver that reconstructs words serialized LSB-first by a right-shift transmitter.

---
 rtl/shift_deser_pkg.sv | 16 +
 rtl/shift_deser_if.sv | 16 +
 rtl/shift_deser_sipo_core.sv | 43 ++++
 rtl/shift_deser.sv | 110 +++++++++++
 tb/tb_shift_deser.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_deser_pkg.sv
// Shared definitions for the shift_deser serial receiver: FSM state codes and line levels.
// These constants stand in for the former shift_defs.vh include and keep its encodings.
package shift_deser_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_STOP  = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

    localparam logic LINE_IDLE = 1'b1;

    function automatic logic state_busy(input logic [1:0] st);
        return st != ST_IDLE;
    endfunction

endpackage

// File: rtl/shift_deser_if.sv
// Serial-line inputs and parallel-word handshake outputs of shift_deser.
interface shift_deser_if #(parameter int W = 4);

    logic         En;
    logic         Ser;
    logic         Rdy;
    logic [W-1:0] Q;
    logic         Vld;
    logic         Busy;
    logic         FrmErr;
    logic         Ovr;

    modport master (output En, Ser, Rdy, input Q, Vld, Busy, FrmErr, Ovr);
    modport slave  (input En, Ser, Rdy, output Q, Vld, Busy, FrmErr, Ovr);

endinterface

// File: rtl/shift_deser_sipo_core.sv
// W-bit right shift register (new bit enters at the MSB) plus data-bit counter.
module sipo_core #(
    parameter int W  = 4,
    parameter int CW = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en_i,
    input  logic         clear_i,
    input  logic         ser_i,
    output logic [W-1:0] sr_o,
    output logic         last_o
);

    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_en_i) begin
            sr_d  = {ser_i, sr_q[W-1:1]};
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // High while the shift about to happen is the W-th data bit.
    assign last_o = (cnt_q == CW'(W - 1));
    assign sr_o   = sr_q;

endmodule

// File: rtl/shift_deser.sv
// LSB-first serial frame receiver: FSM, output word register and valid/ready handshake.
// All state advances on the falling edge of Clk.
module shift_deser
    import shift_deser_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = 3
) (
    input  logic          Clk,
    input  logic          Rst,
    shift_deser_if.slave  bus
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] q_q, q_d;
    logic         vld_q, vld_d;
    logic         fe_q, fe_d;
    logic         ovr_q, ovr_d;

    logic         shift_en;
    logic         clear;
    logic         good;
    logic         last;
    logic [W-1:0] sr;

    sipo_core #(.W(W), .CW(CW)) u_core (
        .clk        (Clk),
        .rst        (Rst),
        .shift_en_i (shift_en),
        .clear_i    (clear),
        .ser_i      (bus.Ser),
        .sr_o       (sr),
        .last_o     (last)
    );

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        clear    = 1'b0;
        good     = 1'b0;
        fe_d     = 1'b0;
        if (bus.En) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.Ser != LINE_IDLE) begin
                        state_d = ST_DATA;
                        clear   = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_en = 1'b1;
                    if (last) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (bus.Ser == LINE_IDLE) begin
                        good    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (bus.Ser == LINE_IDLE) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A completed word wins over a plain accept; with Rdy=1 it replaces Q back-to-back.
    always_comb begin
        q_d   = q_q;
        vld_d = vld_q;
        ovr_d = 1'b0;
        if (good) begin
            if (!vld_q || bus.Rdy) begin
                q_d   = sr;
                vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (vld_q && bus.Rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            vld_q   <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            vld_q   <= vld_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.Vld    = vld_q;
    assign bus.Busy   = state_busy(state_q);
    assign bus.FrmErr = fe_q;
    assign bus.Ovr    = ovr_q;

endmodule

// File: tb/tb_shift_deser.sv
// Directed-frame bench for shift_deser with a per-cycle reference model.
module tb_shift_deser;

    localparam int W = 4;

    logic Clk;
    logic Rst;

    shift_deser_if #(.W(W)) bus ();

    shift_deser #(.W(W), .CW(3)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model: phase 0 idle, 1 collecting data, 2 expecting stop, 3 break.
    int           ph;
    int           nb;
    logic [W-1:0] acc;
    logic [W-1:0] mq;
    logic         mvld, mfe, movr;

    always @(negedge Clk or posedge Rst) begin
        logic done;
        if (Rst) begin
            ph = 0; nb = 0; acc = '0; mq = '0;
            mvld = 1'b0; mfe = 1'b0; movr = 1'b0;
        end else begin
            done = 1'b0;
            mfe  = 1'b0;
            movr = 1'b0;
            if (bus.En) begin
                if (ph == 0) begin
                    if (bus.Ser == 1'b0) begin ph = 1; nb = 0; acc = '0; end
                end else if (ph == 1) begin
                    acc[nb] = bus.Ser;
                    nb = nb + 1;
                    if (nb == W) ph = 2;
                end else if (ph == 2) begin
                    if (bus.Ser) begin done = 1'b1; ph = 0; end
                    else begin mfe = 1'b1; ph = 3; end
                end else begin
                    if (bus.Ser) ph = 0;
                end
            end
            if (done) begin
                if (!mvld || bus.Rdy) begin mq = acc; mvld = 1'b1; end
                else movr = 1'b1;
            end else if (mvld && bus.Rdy) begin
                mvld = 1'b0;
            end
        end
    end

    always @(posedge Clk) begin
        n_vec++;
        if ({bus.Q, bus.Vld, bus.Busy, bus.FrmErr, bus.Ovr} !==
            {mq, mvld, (ph != 0), mfe, movr}) begin
            n_err++;
            $display("FAIL cycle t=%0t: dut Q=%h Vld=%b Busy=%b FrmErr=%b Ovr=%b, model Q=%h Vld=%b Busy=%b FrmErr=%b Ovr=%b",
                     $time, bus.Q, bus.Vld, bus.Busy, bus.FrmErr, bus.Ovr,
                     mq, mvld, (ph != 0), mfe, movr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic ser, input logic rdy);
        @(posedge Clk);
        #1;
        bus.En  = en;
        bus.Ser = ser;
        bus.Rdy = rdy;
    endtask

    // Start, W data bits LSB first, stop; En=0 gap cycles toggle Ser to prove it is ignored.
    task automatic send_frame(input logic [W-1:0] w, input logic stopb,
                              input int period, input logic rdy_stop);
        logic [W+1:0] bits;
        logic         s;
        bits = {stopb, w, 1'b0};
        for (int i = 0; i < W + 2; i++) begin
            cyc(1'b1, bits[i], (i == W + 1) ? rdy_stop : 1'b0);
            s = ~bits[i];
            for (int g = 1; g < period; g++) begin
                cyc(1'b0, s, 1'b0);
                s = ~s;
            end
        end
    endtask

    task automatic after_edge();
        @(negedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.En  = 1'b0;
        bus.Ser = 1'b1;
        bus.Rdy = 1'b0;
        Rst     = 1'b1;
        #1;
        check("rst_Q", bus.Q, 0);
        check("rst_Vld", bus.Vld, 0);
        check("rst_Busy", bus.Busy, 0);
        check("rst_FrmErr", bus.FrmErr, 0);
        check("rst_Ovr", bus.Ovr, 0);
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);

        // Async reset in the middle of a frame, then a clean frame.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        after_edge();
        check("t1_busy_before_rst", bus.Busy, 1);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("t1_Q_rst", bus.Q, 0);
        check("t1_Vld_rst", bus.Vld, 0);
        check("t1_Busy_rst", bus.Busy, 0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        bus.En = 1'b0;
        bus.Ser = 1'b1;
        send_frame(4'h6, 1'b1, 1, 1'b0);
        after_edge();
        check("t1_Q_clean", bus.Q, 4'h6);
        check("t1_Vld_clean", bus.Vld, 1);
        cyc(1'b0, 1'b1, 1'b1);
        after_edge();
        check("t1_accept_Vld", bus.Vld, 0);
        check("t1_accept_Q", bus.Q, 4'h6);

        // Ser = 0,1,0,1,1,1 with En every cycle -> 4'hD.
        send_frame(4'hD, 1'b1, 1, 1'b0);
        after_edge();
        check("t2_Q", bus.Q, 4'hD);
        check("t2_model_Q", mq, 4'hD);
        check("t2_Vld", bus.Vld, 1);
        check("t2_FrmErr", bus.FrmErr, 0);
        check("t2_Ovr", bus.Ovr, 0);

        // Second word while unaccepted -> dropped with Ovr pulse.
        send_frame(4'h3, 1'b1, 1, 1'b0);
        after_edge();
        check("t3_Ovr", bus.Ovr, 1);
        check("t3_model_Ovr", movr, 1);
        check("t3_Q", bus.Q, 4'hD);
        check("t3_Vld", bus.Vld, 1);
        cyc(1'b0, 1'b1, 1'b0);
        after_edge();
        check("t3_Ovr_pulse_end", bus.Ovr, 0);

        // Bad stop bit, line held low for 3 strobes, then released.
        send_frame(4'h9, 1'b0, 1, 1'b0);
        after_edge();
        check("t4_FrmErr", bus.FrmErr, 1);
        check("t4_model_FrmErr", mfe, 1);
        check("t4_Ovr", bus.Ovr, 0);
        check("t4_Vld", bus.Vld, 1);
        check("t4_Q", bus.Q, 4'hD);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
        after_edge();
        check("t4_Busy_break", bus.Busy, 1);
        check("t4_FrmErr_pulse_end", bus.FrmErr, 0);
        cyc(1'b1, 1'b1, 1'b0);
        after_edge();
        check("t4_Busy_idle", bus.Busy, 0);
        check("t4_Q_kept", bus.Q, 4'hD);

        // Accept, then a strobed-every-3rd-cycle frame carrying 4'hA.
        cyc(1'b0, 1'b1, 1'b1);
        after_edge();
        check("t5_accept_Vld", bus.Vld, 0);
        send_frame(4'hA, 1'b1, 3, 1'b0);
        after_edge();
        check("t5_Q", bus.Q, 4'hA);
        check("t5_model_Q", mq, 4'hA);
        check("t5_Vld", bus.Vld, 1);

        // Back-to-back: Rdy high only on the stop edge of frame 4'h5.
        send_frame(4'h5, 1'b1, 1, 1'b1);
        after_edge();
        check("t6_Q", bus.Q, 4'h5);
        check("t6_model_Q", mq, 4'h5);
        check("t6_Vld", bus.Vld, 1);
        check("t6_Ovr", bus.Ovr, 0);

        // Start bit directly after a stop-bit strobe.
        cyc(1'b0, 1'b1, 1'b1);
        send_frame(4'hC, 1'b1, 1, 1'b0);
        send_frame(4'h7, 1'b1, 1, 1'b1);
        after_edge();
        check("t7_Q", bus.Q, 4'h7);
        check("t7_Vld", bus.Vld, 1);

        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        @(posedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
